// File: rtl/block_test_pkg.sv
// Shared definitions for the 257-bit block test datapath: block width,
// mode encodings, LFSR taps, checker FSM states and the block-advance function.
package block_test_pkg;

  localparam int BLOCK_SIZE = 257;

  localparam logic [1:0] CFG_SEQUENCE = 2'b00;
  localparam logic [1:0] CFG_RANDOM   = 2'b01;
  localparam logic [1:0] CFG_FIXED    = 2'b10;

  localparam int TAP_A = 256;
  localparam int TAP_B = 255;
  localparam int TAP_C = 253;
  localparam int TAP_D = 251;

  localparam logic [BLOCK_SIZE-1:0] ALL_ONES = {BLOCK_SIZE{1'b1}};

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // One whole block of LFSR steps: the block that follows s in the stream.
  function automatic logic [BLOCK_SIZE-1:0] lfsr_advance(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] t;
    logic                  fb;
    t = s;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      fb = t[TAP_A] ^ t[TAP_B] ^ t[TAP_C] ^ t[TAP_D];
      t  = {t[BLOCK_SIZE-2:0], fb};
    end
    return t;
  endfunction

endpackage

// File: rtl/block_popcount.sv
// Combinational count of set bits across a block; reusable by any error monitor.
module block_popcount
  import block_test_pkg::*;
#(
  parameter int WIDTH = BLOCK_SIZE
) (
  input  logic [WIDTH-1:0]           data,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] acc_s;

  // Sum every bit of the input into a CW-bit count.
  always_comb begin
    acc_s = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      acc_s = acc_s + CW'(data[i]);
    end
    count = acc_s;
  end

endmodule

// File: rtl/block_checker.sv
// Receive-side block checker: self-synchronises to the generator LFSR stream
// (sequence mode) or to all-ones (fixed mode) and keeps lock/error statistics.
module block_checker
  import block_test_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_config,
  input  logic                  i_clear,
  input  logic [BLOCK_SIZE-1:0] data_in,
  input  logic                  valid_in,
  output logic                  o_locked,
  output logic                  o_block_err,
  output logic [CNT_W-1:0]      o_blocks,
  output logic [CNT_W-1:0]      o_err_blocks,
  output logic [CNT_W-1:0]      o_bit_errs
);

  localparam int MW  = $clog2(LOCK_COUNT + 1);
  localparam int XW  = $clog2(ERR_THRESH + 1);
  localparam int PW  = $clog2(BLOCK_SIZE + 1);

  localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [XW-1:0]    MISS_LAST  = XW'(ERR_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  chk_state_e            state_r, state_nxt_s;
  logic [BLOCK_SIZE-1:0] expected_r, expected_nxt_s;
  logic [MW-1:0]         match_r, match_nxt_s;
  logic [XW-1:0]         miss_r, miss_nxt_s;
  logic                  locked_nxt_s;
  logic                  block_err_nxt_s;
  logic                  err_hit_s;
  logic [1:0]            cfg_prev_r;
  logic                  cfg_change_s;
  logic                  mode_seq_s;
  logic                  mode_fixed_s;
  logic [BLOCK_SIZE-1:0] ref_s;
  logic [BLOCK_SIZE-1:0] diff_s;
  logic                  mismatch_s;
  logic [BLOCK_SIZE-1:0] adv_src_s;
  logic [BLOCK_SIZE-1:0] adv_s;
  logic [PW-1:0]         diff_cnt_s;
  logic [CNT_W:0]        bit_sum_s;

  // Decode the mode; reserved encoding behaves as random (count only).
  always_comb begin
    mode_seq_s   = 1'b0;
    mode_fixed_s = 1'b0;
    case (i_config)
      CFG_SEQUENCE: mode_seq_s   = 1'b1;
      CFG_FIXED:    mode_fixed_s = 1'b1;
      CFG_RANDOM:   mode_seq_s   = 1'b0;
      default:      mode_seq_s   = 1'b0;
    endcase
    cfg_change_s = (i_config != cfg_prev_r);
  end

  // Reference block, bit difference and the single shared LFSR advance.
  // SEARCH seeds from the received block; otherwise tracking runs off the
  // expected register so bit errors never corrupt the prediction.
  always_comb begin
    if (mode_fixed_s) begin
      ref_s = ALL_ONES;
    end else begin
      ref_s = expected_r;
    end
    diff_s     = data_in ^ ref_s;
    mismatch_s = |diff_s;
    if (state_r == ST_SEARCH) begin
      adv_src_s = data_in;
    end else begin
      adv_src_s = expected_r;
    end
    adv_s = lfsr_advance(adv_src_s);
  end

  block_popcount #(.WIDTH(BLOCK_SIZE)) u_popcount (
    .data  (diff_s),
    .count (diff_cnt_s)
  );

  // Next-state and next-output logic of the search/verify/locked FSM.
  always_comb begin
    state_nxt_s     = state_r;
    expected_nxt_s  = expected_r;
    match_nxt_s     = match_r;
    miss_nxt_s      = miss_r;
    locked_nxt_s    = o_locked;
    block_err_nxt_s = 1'b0;
    err_hit_s       = 1'b0;
    if (cfg_change_s) begin
      state_nxt_s  = ST_SEARCH;
      match_nxt_s  = {MW{1'b0}};
      miss_nxt_s   = {XW{1'b0}};
      locked_nxt_s = 1'b0;
    end else if (valid_in) begin
      case (state_r)
        ST_SEARCH: begin
          if (mode_seq_s) begin
            expected_nxt_s = adv_s;
            match_nxt_s    = {MW{1'b0}};
            state_nxt_s    = ST_VERIFY;
          end else if (mode_fixed_s && !mismatch_s) begin
            if (MATCH_LAST == {MW{1'b0}}) begin
              state_nxt_s  = ST_LOCKED;
              locked_nxt_s = 1'b1;
              match_nxt_s  = {MW{1'b0}};
              miss_nxt_s   = {XW{1'b0}};
            end else begin
              state_nxt_s = ST_VERIFY;
              match_nxt_s = MW'(1);
            end
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end
        ST_VERIFY: begin
          if (mode_seq_s) begin
            expected_nxt_s = adv_s;
          end else begin
            expected_nxt_s = expected_r;
          end
          if (!mode_seq_s && !mode_fixed_s) begin
            state_nxt_s = ST_SEARCH;
            match_nxt_s = {MW{1'b0}};
          end else if (mismatch_s) begin
            state_nxt_s = ST_SEARCH;
            match_nxt_s = {MW{1'b0}};
          end else if (match_r == MATCH_LAST) begin
            state_nxt_s  = ST_LOCKED;
            locked_nxt_s = 1'b1;
            match_nxt_s  = {MW{1'b0}};
            miss_nxt_s   = {XW{1'b0}};
          end else begin
            match_nxt_s = match_r + MW'(1);
          end
        end
        ST_LOCKED: begin
          if (mode_seq_s) begin
            expected_nxt_s = adv_s;
          end else begin
            expected_nxt_s = expected_r;
          end
          if (mismatch_s) begin
            block_err_nxt_s = 1'b1;
            err_hit_s       = 1'b1;
            if (miss_r == MISS_LAST) begin
              state_nxt_s  = ST_SEARCH;
              locked_nxt_s = 1'b0;
              miss_nxt_s   = {XW{1'b0}};
              match_nxt_s  = {MW{1'b0}};
            end else begin
              miss_nxt_s = miss_r + XW'(1);
            end
          end else begin
            miss_nxt_s = {XW{1'b0}};
          end
        end
        default: begin
          state_nxt_s  = ST_SEARCH;
          locked_nxt_s = 1'b0;
          match_nxt_s  = {MW{1'b0}};
          miss_nxt_s   = {XW{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, tracking registers and the registered lock/error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_SEARCH;
      expected_r  <= {BLOCK_SIZE{1'b0}};
      match_r     <= {MW{1'b0}};
      miss_r      <= {XW{1'b0}};
      cfg_prev_r  <= 2'b00;
      o_locked    <= 1'b0;
      o_block_err <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      expected_r  <= expected_nxt_s;
      match_r     <= match_nxt_s;
      miss_r      <= miss_nxt_s;
      cfg_prev_r  <= i_config;
      o_locked    <= locked_nxt_s;
      o_block_err <= block_err_nxt_s;
    end
  end

  // Saturating sum of the running bit-error count and this block's errors.
  always_comb begin
    bit_sum_s = {1'b0, o_bit_errs} + (CNT_W+1)'(diff_cnt_s);
  end

  // Saturating statistics counters with synchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_blocks     <= {CNT_W{1'b0}};
      o_err_blocks <= {CNT_W{1'b0}};
      o_bit_errs   <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      o_blocks     <= {CNT_W{1'b0}};
      o_err_blocks <= {CNT_W{1'b0}};
      o_bit_errs   <= {CNT_W{1'b0}};
    end else begin
      if (valid_in && (o_blocks != CNT_MAX)) begin
        o_blocks <= o_blocks + CNT_W'(1);
      end
      if (err_hit_s) begin
        if (o_err_blocks != CNT_MAX) begin
          o_err_blocks <= o_err_blocks + CNT_W'(1);
        end
        if (bit_sum_s[CNT_W]) begin
          o_bit_errs <= CNT_MAX;
        end else begin
          o_bit_errs <= bit_sum_s[CNT_W-1:0];
        end
      end
    end
  end

endmodule
